// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - shared encodings for the MESI snooping bus and its arbiter
package mesi_pkg;

    localparam logic [1:0] BUS_NONE    = 2'b00;
    localparam logic [1:0] BUS_RD_MISS = 2'b01;
    localparam logic [1:0] BUS_WR_MISS = 2'b10;
    localparam logic [1:0] BUS_INV     = 2'b11;

    localparam logic [1:0] MEM_NONE      = 2'b00;
    localparam logic [1:0] MEM_READ      = 2'b01;
    localparam logic [1:0] MEM_WRITEBACK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BCAST = 3'd1,
        ST_SNOOP = 3'd2,
        ST_WB    = 3'd3,
        ST_MEM   = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting just after the last winner
module rr_picker #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [2:0]       last,
    output logic             found,
    output logic [2:0]       winner
);

    int               idx;
    logic [N_REQ-1:0] cand;

    // Walk the circular order backwards so the first-in-order hit is written last.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 0;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % N_REQ;
            cand = eligible >> idx;
            if (cand[0]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// rtl/mesi_bus_arbiter.sv - snooping bus sequencer: arbitrate, broadcast, snoop, write back, fetch
module mesi_bus_arbiter
    import mesi_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_op,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               shared,
    output logic [1:0]         bus_op,
    output logic [2:0]         bus_src,
    input  logic [N_REQ-1:0]   snoop_hit,
    input  logic [N_REQ-1:0]   snoop_dirty,
    output logic [1:0]         mem_cmd,
    input  logic               mem_ack,
    output logic [2:0]         arb_state
);

    arb_state_t       state;
    logic [2:0]       winner;
    logic [1:0]       op;
    logic [2:0]       last;
    logic             hit_any;
    logic             dirty_any;

    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [2:0]       pick;
    logic [1:0]       pick_op;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] hit_m;
    logic [N_REQ-1:0] dirty_m;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && (req_op[2*i +: 2] != BUS_NONE);
        end
    end

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .eligible (eligible),
        .last     (last),
        .found    (found),
        .winner   (pick)
    );

    assign pick_op    = 2'(req_op >> {pick, 1'b0});
    assign win_onehot = N_REQ'(1) << winner;
    // A requester never snoops its own miss.
    assign hit_m      = snoop_hit & ~win_onehot;
    assign dirty_m    = snoop_dirty & ~win_onehot;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            winner    <= 3'd0;
            op        <= BUS_NONE;
            last      <= 3'(N_REQ - 1);
            hit_any   <= 1'b0;
            dirty_any <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        winner <= pick;
                        op     <= pick_op;
                        state  <= ST_BCAST;
                    end
                end
                ST_BCAST: state <= ST_SNOOP;
                ST_SNOOP: begin
                    hit_any   <= |hit_m;
                    dirty_any <= |dirty_m;
                    if (op == BUS_INV)  state <= ST_DONE;
                    else if (|dirty_m)  state <= ST_WB;
                    else                state <= ST_MEM;
                end
                ST_WB: begin
                    if (mem_ack) state <= (op == BUS_INV) ? ST_DONE : ST_MEM;
                end
                ST_MEM: begin
                    if (mem_ack) state <= ST_DONE;
                end
                ST_DONE: begin
                    last  <= winner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = (state != ST_IDLE) ? win_onehot : '0;
    assign done      = (state == ST_DONE) ? win_onehot : '0;
    assign shared    = (state == ST_DONE) && (op == BUS_RD_MISS) && hit_any;
    assign bus_op    = (state == ST_BCAST) ? op : BUS_NONE;
    assign bus_src   = (state != ST_IDLE) ? winner : 3'd0;
    assign mem_cmd   = (state == ST_WB && dirty_any) ? MEM_WRITEBACK :
                       (state == ST_MEM)             ? MEM_READ      : MEM_NONE;
    assign arb_state = state;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// tb/tb_mesi_bus_arbiter.sv - scoreboard bench for mesi_bus_arbiter
module tb_mesi_bus_arbiter;

    logic       clock;
    logic       resetn;
    logic [2:0] req;
    logic [5:0] req_op;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       shared;
    logic [1:0] bus_op;
    logic [2:0] bus_src;
    logic [2:0] snoop_hit;
    logic [2:0] snoop_dirty;
    logic [1:0] mem_cmd;
    logic       mem_ack;
    logic [2:0] arb_state;

    typedef struct {
        logic [2:0] d;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    mesi_bus_arbiter #(.N_REQ(3)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .req_op      (req_op),
        .gnt         (gnt),
        .done        (done),
        .shared      (shared),
        .bus_op      (bus_op),
        .bus_src     (bus_src),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .mem_cmd     (mem_cmd),
        .mem_ack     (mem_ack),
        .arb_state   (arb_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".gnt"},       32'(gnt),       32'h0);
        chk({tag, ".done"},      32'(done),      32'h0);
        chk({tag, ".shared"},    32'(shared),    32'h0);
        chk({tag, ".bus_op"},    32'(bus_op),    32'h0);
        chk({tag, ".bus_src"},   32'(bus_src),   32'h0);
        chk({tag, ".mem_cmd"},   32'(mem_cmd),   32'h0);
        chk({tag, ".arb_state"}, 32'(arb_state), 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic wait_done(input int idx, input int exp_lat, input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 50) begin
            step();
            n++;
            if (done[idx]) seen = 1;
        end
        chk({name, ".latency"}, 32'(n), 32'(exp_lat));
    endtask

    // Scoreboard monitor: every done pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (resetn && done != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb.unexpected_done: got done=%b shared=%b expected none", done, shared);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (done !== e.d || shared !== e.s) begin
                    failures++;
                    $display("FAIL sb.done: got done=%b shared=%b expected done=%b shared=%b",
                             done, shared, e.d, e.s);
                end
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        req         = '0;
        req_op      = '0;
        snoop_hit   = '0;
        snoop_dirty = '0;
        mem_ack     = 1'b0;
        step();
        chk_reset_outputs("reset");
        step();
        resetn = 1'b1;

        // INV from 0: done after 3 cycles, no memory traffic
        req    = 3'b001;
        req_op = 6'b00_00_11;
        q.push_back('{3'b001, 1'b0});
        step();
        chk("inv.c1.gnt", 32'(gnt), 32'h1);
        chk("inv.c1.bus_op", 32'(bus_op), 32'h3);
        chk("inv.c1.state", 32'(arb_state), 32'h1);
        step();
        chk("inv.c2.gnt", 32'(gnt), 32'h1);
        chk("inv.c2.bus_op", 32'(bus_op), 32'h0);
        chk("inv.c2.mem_cmd", 32'(mem_cmd), 32'h0);
        step();
        chk("inv.c3.gnt", 32'(gnt), 32'h1);
        chk("inv.c3.state", 32'(arb_state), 32'h5);
        chk("inv.c3.done", 32'(done), 32'h1);
        chk("inv.c3.mem_cmd", 32'(mem_cmd), 32'h0);
        req = 3'b000;
        step();
        chk("inv.c4.gnt", 32'(gnt), 32'h0);
        chk("inv.c4.state", 32'(arb_state), 32'h0);

        // Two RD_MISS requesters, immediate acks, snooper 1 hits
        do_reset();
        req       = 3'b011;
        req_op    = 6'b00_01_01;
        mem_ack   = 1'b1;
        snoop_hit = 3'b010;
        q.push_back('{3'b001, 1'b1});
        q.push_back('{3'b010, 1'b0});
        wait_done(0, 4, "rd0");
        req = 3'b010;
        wait_done(1, 5, "rd1");
        req       = 3'b000;
        mem_ack   = 1'b0;
        snoop_hit = 3'b000;
        step();

        // Dirty RD_MISS from 2, acks delayed two cycles per command
        req         = 3'b100;
        req_op      = 6'b01_00_00;
        snoop_hit   = 3'b001;
        snoop_dirty = 3'b001;
        q.push_back('{3'b100, 1'b1});
        step();
        chk("dirty.bcast.src", 32'(bus_src), 32'h2);
        chk("dirty.bcast.gnt", 32'(gnt), 32'h4);
        chk("dirty.bcast.op", 32'(bus_op), 32'h1);
        step();
        chk("dirty.snoop.state", 32'(arb_state), 32'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dirty.wb%0d", k), 32'(mem_cmd), 32'h2);
            mem_ack = (k == 2);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dirty.rd%0d", k), 32'(mem_cmd), 32'h1);
            mem_ack = (k == 2);
        end
        step();
        chk("dirty.done.state", 32'(arb_state), 32'h5);
        chk("dirty.done.mem_cmd", 32'(mem_cmd), 32'h0);
        mem_ack     = 1'b0;
        req         = 3'b000;
        snoop_hit   = 3'b000;
        snoop_dirty = 3'b000;
        step();

        // Continuous requests from all three: fair rotation 0,1,2,0,1,2
        do_reset();
        req     = 3'b111;
        req_op  = 6'b01_01_01;
        mem_ack = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                q.push_back('{3'(1 << i), 1'b0});
            end
        end
        wait_done(0, 4, "rr0");
        wait_done(1, 5, "rr1");
        wait_done(2, 5, "rr2");
        wait_done(0, 5, "rr3");
        wait_done(1, 5, "rr4");
        wait_done(2, 5, "rr5");
        req     = 3'b000;
        mem_ack = 1'b0;
        step();
        step();

        // Reset pulled mid write-back: transaction abandoned, no done
        req         = 3'b010;
        req_op      = 6'b00_01_00;
        snoop_hit   = 3'b001;
        snoop_dirty = 3'b001;
        step();
        step();
        step();
        chk("abort.wb.state", 32'(arb_state), 32'h3);
        chk("abort.wb.mem_cmd", 32'(mem_cmd), 32'h2);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("abort");
        step();
        resetn      = 1'b1;
        snoop_hit   = 3'b000;
        snoop_dirty = 3'b000;
        req         = 3'b011;
        req_op      = 6'b00_01_01;
        mem_ack     = 1'b1;
        q.push_back('{3'b001, 1'b0});
        wait_done(0, 4, "post_reset0");
        req     = 3'b000;
        mem_ack = 1'b0;
        step();
        step();
        step();

        chk("sb.drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mesi_bus_arbiter.md
# mesi_bus_arbiter

Sequencer and round-robin arbiter for the shared snooping bus used by the MESI cache controllers. Up to `N_REQ` controllers raise bus requests (read miss, write miss, invalidate). The block grants one at a time, broadcasts the operation to the snoopers, and collects their hit/dirty responses. It then issues any required write-back and block fetch to memory, and reports completion plus the shared status to the winner. Its state and bus/memory commands also drive the board's seven-segment displays.

## Interface
Parameters:
- `N_REQ`, 3, number of cache controllers on the bus (2..8)

Ports:
- `clock`  in  1  system clock, rising edge
- `resetn`  in  1  reset; asynchronous, active-low
- `req`  in  N_REQ  per-controller bus request; held until matching `done`
- `req_op`  in  2*N_REQ  per-controller bus op, slice i = bits [2i+1:2i]
- `gnt`  out  N_REQ  one-hot grant, held for the whole transaction
- `done`  out  N_REQ  one-cycle completion pulse to the winner
- `shared`  out  1  valid with `done`: another cache reported a hit
- `bus_op`  out  2  operation broadcast to snoopers
- `bus_src`  out  3  index of current owner
- `snoop_hit`  in  N_REQ  snooper i holds the line (S/E/M)
- `snoop_dirty`  in  N_REQ  snooper i holds the line in M
- `mem_cmd`  out  2  command to memory
- `mem_ack`  in  1  memory completed current command
- `arb_state`  out  3  current FSM state, for display

## Operation
- Bus ops: 00 NONE, 01 RD_MISS, 10 WR_MISS, 11 INV.
- Mem cmds: 00 NONE, 01 READ, 10 WRITEBACK.
- Eligible requester: `req[i]=1` and op != NONE.
- Round-robin: the search starts at index `last+1` and wraps at N_REQ-1. The lowest eligible index in that circular order wins.
- FSM states and codes: IDLE 0, BCAST 1, SNOOP 2, WB 3, MEM 4, DONE 5.
  - IDLE: if any requester is eligible, latch the winner index and op, then go to BCAST. Otherwise stay in IDLE.
  - BCAST (1 cycle): `bus_op` = latched op; `bus_src` = winner. Next state is SNOOP.
  - SNOOP (1 cycle): sample `snoop_hit`/`snoop_dirty` with the winner's own bit masked. Register `hit_any` and `dirty_any`. Next state:
    - op INV: DONE.
    - `dirty_any`: WB.
    - otherwise: MEM.
  - WB: `mem_cmd`=WRITEBACK until the cycle `mem_ack`=1. Then go to MEM; for op INV, which is unreachable, go to DONE.
  - MEM: `mem_cmd`=READ until the cycle `mem_ack`=1, then DONE.
  - DONE (1 cycle): `done[winner]`=1. `shared` = `hit_any` for RD_MISS, otherwise 0. Set `last` = winner. Next state is IDLE.
- `gnt[winner]`=1 from BCAST through DONE inclusive; 0 in IDLE.
- `bus_op`=NONE outside BCAST.
- `bus_src` holds the latched winner while `gnt` is active and is 0 otherwise.

## Timing
- Reset (async assert, sync to FSM on release):
  - IDLE; `gnt`=0, `done`=0, `shared`=0, `bus_op`=00, `bus_src`=0, `mem_cmd`=00, `arb_state`=0.
  - `last`=N_REQ-1, so requester 0 wins first.
- All outputs are registered, or decoded from registered state only.
- Latency from IDLE with a request present to `done`:
  - INV: 3 cycles.
  - Clean miss with immediate ack: 4 cycles.
  - Dirty miss with immediate acks: 5 cycles.
- `mem_ack` in the same cycle `mem_cmd` first asserts completes that command. Each command is visible for at least 1 cycle.
- `mem_ack` outside WB/MEM is ignored.
- A winner dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses.
- A request changing `req_op` after IDLE is ignored, because the op was latched.
- Requests arriving during a transaction wait. Re-arbitration happens only in IDLE, one cycle after DONE, so a 1-cycle bus-idle gap exists between transactions.
- Snoop inputs are sampled only in SNOOP.
- `resetn` low mid-transaction abandons it immediately. No `done` is produced; memory must tolerate the dropped command.

## Structure
- Package `mesi_pkg` holds:
  - bus-op constants;
  - mem-cmd constants;
  - the arbiter state enum (3-bit, codes above);
  - the existing MESI state encoding, which controllers share.
- Sub-module `rr_picker`: combinational. Inputs are eligible vector and `last`; outputs are `found` and winner index.
- Everything else (FSM, latches, output decode) stays in `mesi_bus_arbiter`.

## Test plan
- Reset, then `req`=001 with op 11: `gnt`=001 in cycles 1–3; `bus_op`=11 in cycle 1 only; `done[0]` in cycle 3; `mem_cmd` stays 00; `shared`=0.
- `req`=011, both RD_MISS, tie-hold `mem_ack`=1, `snoop_hit[1]`=1: requester 0 is served first with `shared`=1. Requester 1 is served next; its own hit is masked, so `shared`=0.
- RD_MISS from 2 with `snoop_dirty[0]`=1, ack delayed 2 cycles per command:
  - `mem_cmd` is 10 for 3 cycles, then 01 for 3 cycles.
  - `done[2]` follows; `shared`=1.
- All three requesting continuously, with immediate acks: grant order is 0,1,2,0,1,2; no requester is starved.
- `resetn` pulsed low during WB: all outputs return to reset values immediately. No `done` is produced. After reset, requester 0 wins first.
